nf_trace_buf: RTL and testbench

Hardware instruction-trace capture buffer for the nanoFOX CPU. It samples every retired instruction (rising edge of cpu_en) as a {stamp, pc, instr} record into a circular RAM of DEPTH entries. Capture stops a programmable number of commits after a trigger (immediate, PC match or masked instruction match). It sits beside nf_cpu in nf_top, and the bench or a debug port reads the frozen history back by index.

---
 rtl/nf_trace_pkg.sv | 35 +++
 rtl/nf_trace_ram.sv | 27 ++
 rtl/nf_trace_buf.sv | 187 ++++++++++++++++++
 tb/tb_nf_trace_buf.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/nf_trace_pkg.sv
// Shared types and helpers for the nanoFOX instruction-trace buffer.
// Optional stamp storage is enabled by defining NF_TRACE_STAMP_EN.
package nf_trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PRE  = 2'b01,
        ST_POST = 2'b10,
        ST_DONE = 2'b11
    } trace_state_t;

    localparam logic [1:0] TRIG_IMM   = 2'b00;
    localparam logic [1:0] TRIG_PC    = 2'b01;
    localparam logic [1:0] TRIG_INSTR = 2'b10;

    localparam int REC_AW = 32;
    localparam int REC_DW = 32;
    localparam int REC_CW = 32;

    typedef struct packed {
        logic [REC_CW-1:0] stamp;
        logic [REC_AW-1:0] pc;
        logic [REC_DW-1:0] instr;
    } trace_rec_t;

    // Oldest-relative index to physical slot; caller truncates to the pointer width.
    function automatic logic [31:0] phys_addr(
        input logic [31:0] wr_ptr,
        input logic [31:0] count,
        input logic [31:0] idx
    );
        return wr_ptr - count + idx;
    endfunction

endpackage

// File: rtl/nf_trace_ram.sv
// Simple dual-port trace RAM: one write port, one registered read port.
// A read of the address being written returns the previous contents.
module nf_trace_ram
    import nf_trace_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Write port plus registered read (old data on collision)
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
        rdata <= mem_r[raddr];
    end

endmodule

// File: rtl/nf_trace_buf.sv
// Instruction-trace capture buffer for nanoFOX: circular record of retired
// instructions frozen after a trigger. Define NF_TRACE_STAMP_EN to store stamps.
module nf_trace_buf
    import nf_trace_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int CW    = 32
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     cpu_en,
    input  logic [AW-1:0]            pc,
    input  logic [DW-1:0]            instr,
    input  logic                     arm,
    input  logic                     abort,
    input  logic [1:0]               mode,
    input  logic [AW-1:0]            trig_pc,
    input  logic [DW-1:0]            trig_val,
    input  logic [DW-1:0]            trig_mask,
    input  logic [CW-1:0]            post_cnt,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic [AW-1:0]            rd_pc,
    output logic [DW-1:0]            rd_instr,
    output logic [CW-1:0]            rd_stamp,
    output logic [1:0]               state,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     done,
    output logic [CW-1:0]            commit_cnt
);

    localparam int IW   = $clog2(DEPTH);
    localparam int CNTW = IW + 1;
`ifdef NF_TRACE_STAMP_EN
    localparam int RW = CW + AW + DW;
`else
    localparam int RW = AW + DW;
`endif

    trace_state_t    state_r, state_n_s, cap_state_s;
    logic            cpu_en_r;
    logic            commit_s;
    logic            hit_s;
    logic            we_s;
    logic            done_r;
    logic            rd_zero_r;
    logic [IW-1:0]   wr_ptr_r, wr_ptr_n_s, cap_ptr_s, rd_addr_s;
    logic [CNTW-1:0] count_r, count_n_s, cap_count_s;
    logic [CW-1:0]   post_r, post_n_s, cap_post_s;
    logic [CW-1:0]   commit_cnt_r;
    logic [RW-1:0]   wdata_s, rdata_s;

    assign commit_s = cpu_en & ~cpu_en_r;

    // Trigger match for the instruction retiring this cycle
    always_comb begin
        hit_s = 1'b1;
        case (mode)
            TRIG_PC:    hit_s = (pc == trig_pc);
            TRIG_INSTR: hit_s = ((instr & trig_mask) == (trig_val & trig_mask));
            default:    hit_s = 1'b1;
        endcase
    end

    // Capture control: arm first rebases pointers, then the commit is applied on top
    always_comb begin
        state_n_s   = state_r;
        count_n_s   = count_r;
        wr_ptr_n_s  = wr_ptr_r;
        post_n_s    = post_r;
        we_s        = 1'b0;
        cap_state_s = state_r;
        cap_count_s = count_r;
        cap_ptr_s   = wr_ptr_r;
        cap_post_s  = post_r;
        if (abort) begin
            if ((state_r == ST_PRE) || (state_r == ST_POST)) begin
                state_n_s = ST_IDLE;
            end else begin
                state_n_s = state_r;
            end
        end else begin
            if (arm) begin
                cap_state_s = ST_PRE;
                cap_count_s = {CNTW{1'b0}};
                cap_ptr_s   = {IW{1'b0}};
                cap_post_s  = {CW{1'b0}};
            end else begin
                cap_state_s = state_r;
            end
            state_n_s  = cap_state_s;
            count_n_s  = cap_count_s;
            wr_ptr_n_s = cap_ptr_s;
            post_n_s   = cap_post_s;
            // Commits are stored only if capture was already running this cycle
            if (commit_s && ((state_r == ST_PRE) || (state_r == ST_POST))) begin
                we_s       = 1'b1;
                wr_ptr_n_s = cap_ptr_s + IW'(1);
                if (cap_count_s == CNTW'(DEPTH)) begin
                    count_n_s = cap_count_s;
                end else begin
                    count_n_s = cap_count_s + CNTW'(1);
                end
                case (cap_state_s)
                    ST_PRE: begin
                        if (hit_s) begin
                            if (post_cnt == {CW{1'b0}}) begin
                                state_n_s = ST_DONE;
                            end else begin
                                state_n_s = ST_POST;
                                post_n_s  = {CW{1'b0}};
                            end
                        end else begin
                            state_n_s = ST_PRE;
                        end
                    end
                    ST_POST: begin
                        post_n_s = cap_post_s + CW'(1);
                        if (post_n_s == post_cnt) begin
                            state_n_s = ST_DONE;
                        end else begin
                            state_n_s = ST_POST;
                        end
                    end
                    default: state_n_s = cap_state_s;
                endcase
            end else begin
                we_s = 1'b0;
            end
        end
    end

    // Control state, counters and read-masking flag
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r      <= ST_IDLE;
            count_r      <= {CNTW{1'b0}};
            wr_ptr_r     <= {IW{1'b0}};
            post_r       <= {CW{1'b0}};
            commit_cnt_r <= {CW{1'b0}};
            cpu_en_r     <= 1'b0;
            done_r       <= 1'b0;
            rd_zero_r    <= 1'b1;
        end else begin
            state_r      <= state_n_s;
            count_r      <= count_n_s;
            wr_ptr_r     <= wr_ptr_n_s;
            post_r       <= post_n_s;
            commit_cnt_r <= commit_s ? (commit_cnt_r + CW'(1)) : commit_cnt_r;
            cpu_en_r     <= cpu_en;
            done_r       <= (state_n_s == ST_DONE);
            rd_zero_r    <= ({1'b0, rd_idx} >= count_r);
        end
    end

    assign rd_addr_s = IW'(phys_addr(32'(wr_ptr_r), 32'(count_r), 32'(rd_idx)));

`ifdef NF_TRACE_STAMP_EN
    assign wdata_s  = {commit_cnt_r, pc, instr};
    assign rd_stamp = rd_zero_r ? {CW{1'b0}} : rdata_s[RW-1 -: CW];
`else
    assign wdata_s  = {pc, instr};
    assign rd_stamp = {CW{1'b0}};
`endif

    nf_trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (RW)
    ) u_ram (
        .clk   (clk),
        .we    (we_s),
        .waddr (cap_ptr_s),
        .wdata (wdata_s),
        .raddr (rd_addr_s),
        .rdata (rdata_s)
    );

    // Out-of-range reads and post-reset reads are masked to zero
    assign rd_pc      = rd_zero_r ? {AW{1'b0}} : rdata_s[AW+DW-1:DW];
    assign rd_instr   = rd_zero_r ? {DW{1'b0}} : rdata_s[DW-1:0];
    assign state      = state_r;
    assign count      = count_r;
    assign done       = done_r;
    assign commit_cnt = commit_cnt_r;

endmodule

// File: tb/tb_nf_trace_buf.sv
// Directed self-checking bench for nf_trace_buf (DEPTH=8 instance).
module tb_nf_trace_buf;

    logic        clk = 1'b0;
    logic        resetn, cpu_en, arm, abort;
    logic [31:0] pc, instr, trig_pc, trig_val, trig_mask, post_cnt;
    logic [1:0]  mode;
    logic [2:0]  rd_idx;
    logic [31:0] rd_pc, rd_instr, rd_stamp, commit_cnt;
    logic [1:0]  state;
    logic [3:0]  count;
    logic        done;

    int nvec = 0;
    int nerr = 0;

    nf_trace_buf #(.DEPTH(8), .AW(32), .DW(32), .CW(32)) dut (
        .clk(clk), .resetn(resetn), .cpu_en(cpu_en), .pc(pc), .instr(instr),
        .arm(arm), .abort(abort), .mode(mode), .trig_pc(trig_pc),
        .trig_val(trig_val), .trig_mask(trig_mask), .post_cnt(post_cnt),
        .rd_idx(rd_idx), .rd_pc(rd_pc), .rd_instr(rd_instr), .rd_stamp(rd_stamp),
        .state(state), .count(count), .done(done), .commit_cnt(commit_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic commit(input logic [31:0] p, input logic [31:0] i);
        pc = p; instr = i; cpu_en = 1'b1;
        tick();
        cpu_en = 1'b0;
        tick();
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic do_read(input logic [2:0] idx);
        rd_idx = idx;
        tick();
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        tick();
        nvec++; if (state !== 2'b00) begin nerr++; $display("FAIL rst_state: got %0h exp 0", state); end
        nvec++; if (count !== 4'd0) begin nerr++; $display("FAIL rst_count: got %0d exp 0", count); end
        nvec++; if (commit_cnt !== 32'd0) begin nerr++; $display("FAIL rst_commit: got %0d exp 0", commit_cnt); end
        nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL rst_done: got %0b exp 0", done); end
        nvec++; if ({rd_pc, rd_instr, rd_stamp} !== 96'd0) begin nerr++; $display("FAIL rst_rd: got %0h exp 0", {rd_pc, rd_instr, rd_stamp}); end
    endtask

    task automatic test_immediate();
        logic [1:0] exp_st;
        mode = 2'b00; post_cnt = 32'd3;
        pulse_arm();
        nvec++; if (state !== 2'b01) begin nerr++; $display("FAIL imm_armed: got %0h exp 1", state); end
        for (int k = 1; k <= 10; k++) begin
            commit(32'(4 * (k - 1)), 32'h13 + 32'(k));
            exp_st = (k < 4) ? 2'b10 : 2'b11;
            nvec++; if (state !== exp_st) begin nerr++; $display("FAIL imm_state%0d: got %0h exp %0h", k, state, exp_st); end
        end
        nvec++; if (count !== 4'd4) begin nerr++; $display("FAIL imm_count: got %0d exp 4", count); end
        nvec++; if (done !== 1'b1) begin nerr++; $display("FAIL imm_done: got %0b exp 1", done); end
        nvec++; if (commit_cnt !== 32'd10) begin nerr++; $display("FAIL imm_commit: got %0d exp 10", commit_cnt); end
        for (int i = 0; i < 4; i++) begin
            do_read(3'(i));
            nvec++; if (rd_pc !== 32'(4 * i)) begin nerr++; $display("FAIL imm_rdpc%0d: got %0h exp %0h", i, rd_pc, 4 * i); end
            nvec++; if (rd_instr !== 32'h14 + 32'(i)) begin nerr++; $display("FAIL imm_rdinstr%0d: got %0h exp %0h", i, rd_instr, 32'h14 + 32'(i)); end
        end
        do_read(3'd4);
        nvec++; if ({rd_pc, rd_instr} !== 64'd0) begin nerr++; $display("FAIL imm_rd_oob: got %0h exp 0", {rd_pc, rd_instr}); end
    endtask

    task automatic test_pc_wrap();
        logic [31:0] exp_pc;
        mode = 2'b01; trig_pc = 32'h40; post_cnt = 32'd2;
        pulse_arm();
        for (int k = 0; k < 21; k++) begin
            commit(32'(4 * k), 32'h0000_0013);
            if (k == 18) begin
                nvec++; if (state !== 2'b11) begin nerr++; $display("FAIL pc_done_at48: got %0h exp 3", state); end
            end
        end
        nvec++; if (count !== 4'd8) begin nerr++; $display("FAIL pc_count: got %0d exp 8", count); end
        for (int i = 0; i < 8; i++) begin
            do_read(3'(i));
            exp_pc = 32'h2C + 32'(4 * i);
            nvec++; if (rd_pc !== exp_pc) begin nerr++; $display("FAIL pc_rd%0d: got %0h exp %0h", i, rd_pc, exp_pc); end
        end
    endtask

    task automatic test_instr_match();
        mode = 2'b10; trig_mask = 32'h7F; trig_val = 32'h6F; post_cnt = 32'd0;
        pulse_arm();
        commit(32'h100, 32'h0000_0013);
        commit(32'h104, 32'h00A0_0093);
        commit(32'h108, 32'h0000_0033);
        commit(32'h10C, 32'h0000_0067);
        nvec++; if (state !== 2'b01) begin nerr++; $display("FAIL ins_pre: got %0h exp 1", state); end
        commit(32'h110, 32'h0080_006F);
        nvec++; if (state !== 2'b11) begin nerr++; $display("FAIL ins_done: got %0h exp 3", state); end
        nvec++; if (count !== 4'd5) begin nerr++; $display("FAIL ins_count: got %0d exp 5", count); end
        do_read(3'd4);
        nvec++; if (rd_instr !== 32'h0080_006F) begin nerr++; $display("FAIL ins_rd4: got %0h exp 0080006f", rd_instr); end
        nvec++; if (rd_pc !== 32'h110) begin nerr++; $display("FAIL ins_rdpc4: got %0h exp 110", rd_pc); end
    endtask

    task automatic test_abort();
        do_reset();
        mode = 2'b00; post_cnt = 32'd100;
        pulse_arm();
        commit(32'h200, 32'h1);
        commit(32'h204, 32'h2);
        commit(32'h208, 32'h3);
        abort = 1'b1; cpu_en = 1'b1; pc = 32'h20C; instr = 32'h4;
        tick();
        abort = 1'b0; cpu_en = 1'b0;
        tick();
        nvec++; if (state !== 2'b00) begin nerr++; $display("FAIL abt_state: got %0h exp 0", state); end
        nvec++; if (count !== 4'd3) begin nerr++; $display("FAIL abt_count: got %0d exp 3", count); end
        nvec++; if (commit_cnt !== 32'd4) begin nerr++; $display("FAIL abt_commit: got %0d exp 4", commit_cnt); end
        do_read(3'd2);
        nvec++; if (rd_pc !== 32'h208) begin nerr++; $display("FAIL abt_rd2: got %0h exp 208", rd_pc); end
        do_read(3'd3);
        nvec++; if (rd_pc !== 32'd0) begin nerr++; $display("FAIL abt_rd3: got %0h exp 0", rd_pc); end
    endtask

    task automatic test_reset_midrun();
        mode = 2'b00; post_cnt = 32'd100;
        pulse_arm();
        commit(32'h300, 32'h5);
        commit(32'h304, 32'h6);
        rd_idx = 3'd0;
        do_reset();
        nvec++; if (state !== 2'b00) begin nerr++; $display("FAIL mrst_state: got %0h exp 0", state); end
        nvec++; if (count !== 4'd0) begin nerr++; $display("FAIL mrst_count: got %0d exp 0", count); end
        nvec++; if (commit_cnt !== 32'd0) begin nerr++; $display("FAIL mrst_commit: got %0d exp 0", commit_cnt); end
        nvec++; if ({rd_pc, rd_instr, rd_stamp} !== 96'd0) begin nerr++; $display("FAIL mrst_rd: got %0h exp 0", {rd_pc, rd_instr, rd_stamp}); end
        pulse_arm();
        do_read(3'd0);
        nvec++; if ({rd_pc, rd_instr} !== 64'd0) begin nerr++; $display("FAIL mrst_rearm_rd: got %0h exp 0", {rd_pc, rd_instr}); end
    endtask

    task automatic test_edge_detect();
        logic [31:0] exp_stamp;
        do_reset();
        mode = 2'b00; post_cnt = 32'd100;
        pulse_arm();
        pc = 32'h400; instr = 32'h10; cpu_en = 1'b1;
        for (int c = 0; c < 5; c++) tick();
        cpu_en = 1'b0;
        tick();
        for (int k = 1; k <= 3; k++) commit(32'h400 + 32'(4 * k), 32'h10 + 32'(k));
        nvec++; if (commit_cnt !== 32'd4) begin nerr++; $display("FAIL edge_commit: got %0d exp 4", commit_cnt); end
        nvec++; if (count !== 4'd4) begin nerr++; $display("FAIL edge_count: got %0d exp 4", count); end
        for (int i = 0; i < 4; i++) begin
            do_read(3'(i));
`ifdef NF_TRACE_STAMP_EN
            exp_stamp = 32'(i);
`else
            exp_stamp = 32'd0;
`endif
            nvec++; if (rd_stamp !== exp_stamp) begin nerr++; $display("FAIL edge_stamp%0d: got %0d exp %0d", i, rd_stamp, exp_stamp); end
            nvec++; if (rd_pc !== 32'h400 + 32'(4 * i)) begin nerr++; $display("FAIL edge_pc%0d: got %0h exp %0h", i, rd_pc, 32'h400 + 32'(4 * i)); end
        end
    endtask

    initial begin
        resetn = 1'b0; cpu_en = 1'b0; arm = 1'b0; abort = 1'b0;
        pc = 32'd0; instr = 32'd0; mode = 2'b00; trig_pc = 32'd0;
        trig_val = 32'd0; trig_mask = 32'd0; post_cnt = 32'd0; rd_idx = 3'd0;
        tick();
        test_reset();
        test_immediate();
        test_pc_wrap();
        test_instr_match();
        test_abort();
        test_reset_midrun();
        test_edge_detect();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
